cp_ram_init: RTL and testbench

Parametrised single-clock simple dual-port RAM (one write port, one read port) for the cyclic-prefix adder and other OFDM symbol buffers. It generalises the 64 x 8 buffer in width and depth. It adds self-clearing after reset, a registered read with a valid strobe, and defined same-address read/write behaviour. It sits between the IFFT output writer and the CP/symbol reader, both in the baseband clock domain.

---
 rtl/cp_ram_init.sv | 175 +++++++++++++++++
 tb/tb_cp_ram_init.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_ram_init.sv
// Simple dual-port RAM (one write, one read port) with a post-reset clear sweep, a registered read with a valid strobe, and write-first collision handling.
// Optional macro CP_RAM_OUTREG_EN adds a second read output register, giving a read latency of 2.
module cp_ram_init #(
    parameter int                 DATA_W  = 8,
    parameter int                 ADDR_W  = 6,
    parameter logic [DATA_W-1:0]  CLR_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              init_busy,
    output logic              wr_drop
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic                init_busy_q, init_busy_d;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                rd_accept_s;

    // No reset on the array so it maps onto block RAM; the sweep does the clearing.
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // FSM state register together with sweep counter and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= {ADDR_W{1'b0}};
            init_busy_q <= 1'b1;
            wr_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            init_busy_q <= init_busy_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    // FSM next-state logic: sweep every word once, then run
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        init_busy_d = init_busy_q;
        case (state_q)
            ST_INIT: begin
                sweep_cnt_d = sweep_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (sweep_cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_busy_d = 1'b0;
                end else begin
                    state_d     = ST_INIT;
                    init_busy_d = 1'b1;
                end
            end
            ST_RUN: begin
                state_d     = ST_RUN;
                init_busy_d = 1'b0;
            end
            default: begin
                state_d     = ST_INIT;
                sweep_cnt_d = {ADDR_W{1'b0}};
                init_busy_d = 1'b1;
            end
        endcase
    end

    // FSM outputs: steer the write port between sweep and user, flag ignored requests
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        rd_accept_s = 1'b0;
        wr_drop_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = sweep_cnt_q;
                mem_wdata_s = CLR_VAL;
                wr_drop_d   = wr_en | rd_en;
            end
            ST_RUN: begin
                mem_we_s    = wr_en;
                rd_accept_s = rd_en;
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Memory write port
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // First read stage next-state: write-first bypass on same-address collision
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_accept_s) begin
            rd_valid_d = 1'b1;
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem_q[rd_addr];
            end
        end else begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end
    end

    // First read stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef CP_RAM_OUTREG_EN
    logic [DATA_W-1:0] rd_data2_q;
    logic              rd_valid2_q;

    // Second read stage: forwards only completed reads so rd_data holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data2_q  <= {DATA_W{1'b0}};
            rd_valid2_q <= 1'b0;
        end else begin
            rd_valid2_q <= rd_valid_q;
            if (rd_valid_q) begin
                rd_data2_q <= rd_data_q;
            end else begin
                rd_data2_q <= rd_data2_q;
            end
        end
    end

    assign rd_data  = rd_data2_q;
    assign rd_valid = rd_valid2_q;
`else
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign init_busy = init_busy_q;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_cp_ram_init.sv
// Directed self-checking bench for cp_ram_init (DATA_W=8, ADDR_W=6, CLR_VAL=0).
module tb_cp_ram_init;

`ifdef CP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       init_busy;
    logic       wr_drop;

    int checks;
    int errors;

    cp_ram_init #(.DATA_W(8), .ADDR_W(6), .CLR_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_busy (init_busy),
        .wr_drop   (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (init_busy === 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic do_reset();
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = 6'd0; wr_data = 8'h00; rd_addr = 6'd0;
        #22;
        checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0 || init_busy !== 1'b1 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got rd_data=%h rd_valid=%b init_busy=%b wr_drop=%b, want 00 0 1 0",
                     rd_data, rd_valid, init_busy, wr_drop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cyc);
        checks++;
        if (cyc !== 64) begin
            errors++;
            $display("FAIL init_length: got %0d busy cycles, want 64", cyc);
        end
    endtask

    task automatic test_init_clear();
        for (int a = 0; a < 64; a++) begin
            do_read(a[5:0]);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
                errors++;
                $display("FAIL init_clear addr %0d: got valid=%b data=%h, want 1 00", a, rd_valid, rd_data);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(6'd5, 8'hA5);
        do_read(6'd5);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL write_read: got valid=%b data=%h, want 1 a5", rd_valid, rd_data);
        end
        tick();
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_hold: got valid=%b data=%h, want 0 a5", rd_valid, rd_data);
        end
    endtask

    task automatic test_collision();
        wr_en = 1'b1; wr_addr = 6'd10; wr_data = 8'h3C;
        rd_en = 1'b1; rd_addr = 6'd10;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL collision: got valid=%b data=%h, want 1 3c", rd_valid, rd_data);
        end
        do_read(6'd10);
        checks++;
        if (rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL collision_stored: got %h, want 3c", rd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp[0] = 8'hA5; exp[1] = 8'h00; exp[2] = 8'h3C; exp[3] = 8'h00;
        rd_en = 1'b1;
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            case (i)
                0: rd_addr = 6'd5;
                1: rd_addr = 6'd6;
                2: rd_addr = 6'd10;
                3: rd_addr = 6'd11;
                default: rd_en = 1'b0;
            endcase
            tick();
            if (i >= LAT - 1) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp[i-(LAT-1)]) begin
                    errors++;
                    $display("FAIL back_to_back %0d: got valid=%b data=%h, want 1 %h",
                             i, rd_valid, rd_data, exp[i-(LAT-1)]);
                end
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: got valid=%b, want 0", rd_valid);
        end
    endtask

    task automatic test_init_drop();
        int cyc;
        do_reset();
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'hFF;
        rd_en = 1'b1; rd_addr = 6'd3;
        tick();
        checks++;
        if (wr_drop !== 1'b1 || rd_valid !== 1'b0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL init_drop: got wr_drop=%b rd_valid=%b busy=%b, want 1 0 1", wr_drop, rd_valid, init_busy);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        checks++;
        if (wr_drop !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_drop_pulse: got wr_drop=%b rd_valid=%b, want 0 0", wr_drop, rd_valid);
        end
        wait_init(cyc);
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_drop_timeout: got init_busy=%b after %0d cycles, want 0", init_busy, cyc);
        end
        do_read(6'd3);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL init_drop_read: got valid=%b data=%h, want 1 00", rd_valid, rd_data);
        end
        do_read(6'd5);
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reclear_addr5: got %h, want 00", rd_data);
        end
    endtask

    task automatic test_reset_mid_read();
        int cyc;
        do_write(6'd63, 8'h81);
        do_read(6'd63);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h81) begin
            errors++;
            $display("FAIL addr63_write: got valid=%b data=%h, want 1 81", rd_valid, rd_data);
        end
        rd_en = 1'b1; rd_addr = 6'd63;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0 || init_busy !== 1'b1 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read: got rd_data=%h rd_valid=%b busy=%b wr_drop=%b, want 00 0 1 0",
                     rd_data, rd_valid, init_busy, wr_drop);
        end
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cyc);
        checks++;
        if (cyc !== 64) begin
            errors++;
            $display("FAIL reinit_length: got %0d, want 64", cyc);
        end
        do_read(6'd63);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reinit_addr63: got valid=%b data=%h, want 1 00", rd_valid, rd_data);
        end
    endtask

    task automatic test_read_then_write();
        do_write(6'd7, 8'h5A);
        rd_en = 1'b1; rd_addr = 6'd7;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 8'h11;
        tick();
        wr_en = 1'b0;
        checks++;
        if (rd_data !== 8'h5A || rd_valid !== (LAT == 2 ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL read_then_write: got valid=%b data=%h, want %b 5a",
                     rd_valid, rd_data, (LAT == 2 ? 1'b1 : 1'b0));
        end
        tick();
        do_read(6'd7);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h11) begin
            errors++;
            $display("FAIL read_after_write: got valid=%b data=%h, want 1 11", rd_valid, rd_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_init_clear();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_init_drop();
        test_reset_mid_read();
        test_read_then_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
